// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: FSM state encodings.
package program_loader_pkg;

    localparam int LdrStateBits = 3;

    localparam logic [LdrStateBits-1:0] LDR_RUN     = 3'd0;
    localparam logic [LdrStateBits-1:0] LDR_HOLD    = 3'd1;
    localparam logic [LdrStateBits-1:0] LDR_LOAD    = 3'd2;
    localparam logic [LdrStateBits-1:0] LDR_RELEASE = 3'd3;
    localparam logic [LdrStateBits-1:0] LDR_ERROR   = 3'd4;

endpackage

// File: rtl/program_loader_register.sv
// Plain enable register with synchronous active-low clear (same shape as the program counter).
module program_loader_register #(
    parameter int DataBits = 8
) (
    input  logic                clock,
    input  logic                bReset,
    input  logic                write_enable,
    input  logic [DataBits-1:0] data_in,
    output logic [DataBits-1:0] data_out
);

    always_ff @(posedge clock) begin
        if (!bReset)
            data_out <= '0;
        else if (write_enable)
            data_out <= data_in;
    end

endmodule

// File: rtl/program_loader.sv
// Boot/load controller: freezes the CPU, streams a byte image into program RAM, then
// holds the CPU in reset for a few cycles and lets it run from address 0.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int AddrBits      = 4,
    parameter int DataBits      = 8,
    parameter int Depth         = 16,
    parameter int TimeoutCycles = 255,
    parameter int ResetCycles   = 4
) (
    input  logic                clock,
    input  logic                bReset,
    input  logic                load_start,
    input  logic                byte_valid,
    input  logic [DataBits-1:0] byte_data,
    output logic                byte_ready,
    input  logic [AddrBits-1:0] cpu_ram_addr,
    input  logic [DataBits-1:0] cpu_ram_data,
    input  logic                cpu_ram_we,
    output logic [AddrBits-1:0] ram_addr,
    output logic [DataBits-1:0] ram_data,
    output logic                ram_we,
    output logic                cpu_hold,
    output logic                cpu_bReset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    logic [LdrStateBits-1:0] state;
    logic [AddrBits-1:0]     addr_cnt;
    logic [7:0]              idle_cnt;
    logic [2:0]              rst_cnt;
    logic                    done_q;
    logic                    in_run, in_hold, in_load, transfer, last_byte;

    assign in_run    = (state == LDR_RUN);
    assign in_hold   = (state == LDR_HOLD);
    assign in_load   = (state == LDR_LOAD);
    assign transfer  = in_load & byte_valid;
    assign last_byte = (addr_cnt == AddrBits'(Depth - 1));

    // HOLD clears the write pointer through the register's own clear input.
    program_loader_register #(.DataBits(AddrBits)) addr_reg (
        .clock        (clock),
        .bReset       (bReset & ~in_hold),
        .write_enable (transfer),
        .data_in      (addr_cnt + AddrBits'(1)),
        .data_out     (addr_cnt)
    );

    always_ff @(posedge clock) begin
        if (!bReset) begin
            state    <= LDR_RUN;
            idle_cnt <= '0;
            rst_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LDR_RUN:
                    if (load_start) state <= LDR_HOLD;
                LDR_HOLD: begin
                    idle_cnt <= '0;
                    state    <= LDR_LOAD;
                end
                LDR_LOAD:
                    if (transfer) begin
                        idle_cnt <= '0;
                        if (last_byte) begin
                            state   <= LDR_RELEASE;
                            rst_cnt <= '0;
                        end
                    end else if (idle_cnt == 8'(TimeoutCycles - 1)) begin
                        state <= LDR_ERROR;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                LDR_RELEASE:
                    if (rst_cnt == 3'(ResetCycles - 1)) begin
                        state   <= LDR_RUN;
                        done_q  <= 1'b1;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 3'd1;
                    end
                LDR_ERROR:
                    if (load_start) state <= LDR_HOLD;
                default:
                    state <= LDR_RUN;
            endcase
        end
    end

    assign byte_ready = in_load;
    assign cpu_hold   = ~in_run;
    assign cpu_bReset = in_run;
    assign busy       = ~in_run;
    assign done       = done_q;
    assign error      = (state == LDR_ERROR);

    // CPU owns the RAM port only while running; its writes are dropped otherwise.
    assign ram_addr = in_run ? cpu_ram_addr : addr_cnt;
    assign ram_data = in_run ? cpu_ram_data : byte_data;
    assign ram_we   = in_run ? cpu_ram_we   : transfer;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: behavioural model checked every cycle plus literal RAM/timing checks.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       bReset, load_start, byte_valid, cpu_ram_we;
    logic [7:0] byte_data, cpu_ram_data;
    logic [3:0] cpu_ram_addr;
    logic       byte_ready, ram_we, cpu_hold, cpu_bReset, busy, done, error;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;

    int total = 0;
    int bad   = 0;

    program_loader dut (
        .clock        (clock),
        .bReset       (bReset),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .cpu_ram_addr (cpu_ram_addr),
        .cpu_ram_data (cpu_ram_data),
        .cpu_ram_we   (cpu_ram_we),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .cpu_hold     (cpu_hold),
        .cpu_bReset   (cpu_bReset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: which phase we are in and how many bytes/cycles have elapsed.
    localparam int M_RUN = 0, M_HOLD = 1, M_LOAD = 2, M_REL = 3, M_ERR = 4;
    int  m_mode = M_RUN, m_loaded = 0, m_idle = 0, m_rel = 0;
    bit  m_done = 0, chk_en = 0;

    always @(posedge clock) begin
        if (!bReset) begin
            m_mode = M_RUN; m_loaded = 0; m_idle = 0; m_rel = 0; m_done = 0;
            chk_en = 1;
        end else begin
            m_done = 0;
            case (m_mode)
                M_RUN:  if (load_start) m_mode = M_HOLD;
                M_HOLD: begin m_loaded = 0; m_idle = 0; m_mode = M_LOAD; end
                M_LOAD:
                    if (byte_valid) begin
                        m_loaded++; m_idle = 0;
                        if (m_loaded == 16) begin m_loaded = 0; m_rel = 0; m_mode = M_REL; end
                    end else begin
                        m_idle++;
                        if (m_idle == 255) m_mode = M_ERR;
                    end
                M_REL: begin
                    m_rel++;
                    if (m_rel == 4) begin m_mode = M_RUN; m_done = 1; end
                end
                default: if (load_start) m_mode = M_HOLD;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            bit run;
            run = (m_mode == M_RUN);
            check("byte_ready", byte_ready, m_mode == M_LOAD);
            check("cpu_hold",   cpu_hold,   !run);
            check("cpu_bReset", cpu_bReset, run);
            check("busy",       busy,       !run);
            check("error",      error,      m_mode == M_ERR);
            check("done",       done,       m_done);
            check("ram_we",     ram_we,     run ? cpu_ram_we : (m_mode == M_LOAD && byte_valid));
            check("ram_addr",   ram_addr,   run ? cpu_ram_addr : 4'(m_loaded));
            check("ram_data",   ram_data,   run ? cpu_ram_data : byte_data);
        end
    end

    // The RAM the controller drives.
    logic [7:0] ram [16];
    initial for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    always @(negedge clock) if (ram_we === 1'b1) ram[ram_addr] = ram_data;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_image(input logic [7:0] base, input int n, input int gap, input bit junk);
        load_start = 1'b1;
        byte_valid = junk; byte_data = 8'hEE;
        step();
        load_start = 1'b0;
        step();
        byte_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) step();
            byte_valid = 1'b1; byte_data = base + 8'(i);
            step();
            byte_valid = 1'b0;
        end
    endtask

    task automatic check_release(input string tag);
        int low = 0, pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!cpu_bReset) low++;
            if (done) pulses++;
        end
        check({tag, "_reset_cycles"}, low, 4);
        check({tag, "_done_pulses"}, pulses, 1);
        step();
    endtask

    task automatic check_img(input string tag, input logic [7:0] base, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            check($sformatf("%s_ram%0d", tag, i), ram[i], base + 8'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bReset = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        cpu_ram_addr = 4'd0; cpu_ram_data = 8'h00; cpu_ram_we = 1'b0;

        // 1: reset, CPU pass-through
        step(); step();
        check("rst_byte_ready", byte_ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        bReset = 1'b1;
        cpu_ram_we = 1'b1; cpu_ram_addr = 4'd5; cpu_ram_data = 8'hA5;
        @(negedge clock);
        check("t1_ram_we", ram_we, 1);
        check("t1_ram_addr", ram_addr, 5);
        check("t1_ram_data", ram_data, 8'hA5);
        check("t1_cpu_bReset", cpu_bReset, 1);
        check("t1_cpu_hold", cpu_hold, 0);
        check("t1_busy", busy, 0);
        step();
        cpu_ram_we = 1'b0;

        // 2: back-to-back image
        load_start = 1'b1;
        step();
        check("t2_hold_latency", cpu_hold, 1);
        load_start = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            byte_valid = 1'b1; byte_data = 8'h10 + 8'(i);
            step();
        end
        byte_valid = 1'b0;
        check_release("t2");
        check_img("t2", 8'h10, 0, 15);

        // 3: gapped stream, early byte_valid in RUN/HOLD must not write
        load_image(8'h20, 16, 3, 1'b1);
        check_release("t3");
        check_img("t3", 8'h20, 0, 15);

        // 4: stall after 7 bytes -> timeout, then full reload
        load_image(8'h30, 7, 0, 1'b0);
        n = 0;
        while (!error && n < 400) begin step(); n++; end
        check("t4_timeout_cycles", n, 255);
        check_img("t4", 8'h30, 0, 6);
        check("t4_ram7_kept", ram[7], 8'h27);
        load_image(8'h40, 16, 0, 1'b0);
        check_release("t4r");
        check_img("t4r", 8'h40, 0, 15);

        // 5: reset in the middle of a load
        load_image(8'h50, 9, 0, 1'b0);
        bReset = 1'b0;
        step();
        bReset = 1'b1;
        check("t5_cpu_bReset", cpu_bReset, 1);
        check("t5_cpu_hold", cpu_hold, 0);
        check("t5_error", error, 0);
        check("t5_done", done, 0);
        check_img("t5", 8'h50, 0, 8);
        check("t5_ram9_kept", ram[9], 8'h49);

        // 6: CPU writes blocked during load (also proves addr restarts at 0 after reset)
        cpu_ram_we = 1'b1; cpu_ram_addr = 4'd3; cpu_ram_data = 8'hFF;
        load_image(8'h60, 16, 1, 1'b0);
        cpu_ram_we = 1'b0;
        check_release("t6");
        check_img("t6", 8'h60, 0, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
